histogram_bin_ctrl: RTL and testbench

HISTOGRAM_BIN_CTRL -- requirements
Module: histogram_bin_ctrl

---
 rtl/histogram_bin_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_histogram_bin_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_bin_ctrl.sv
// Histogram bin controller: serialises bin increments (read-modify-write), host reads
// and full clears onto a single-port bin RAM with one-cycle synchronous read latency.
module histogram_bin_ctrl #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_req_i,
  input  logic [ADDR_W-1:0] inc_addr_i,
  input  logic              clr_req_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [CNT_W-1:0]  mem_wdata_o,
  input  logic [CNT_W-1:0]  mem_rdata_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INC_RD   = 3'd1,
    S_INC_WR   = 3'd2,
    S_HOST_RD  = 3'd3,
    S_HOST_RSP = 3'd4,
    S_CLEAR    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W:0]   DROP_MAX = {1'b0, {DROP_W{1'b1}}};

  state_t            state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              clr_lat_q, clr_lat_d;
  logic              clr_done_q, clr_done_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              clr_any_s;
  logic              pend_any_s;
  logic              consume_s;
  logic              enter_clr_s;
  logic [1:0]        drops_s;
  logic [DROP_W:0]   drop_sum_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Next-state arbitration: clear > pending increment > host read
  always_comb begin
    state_d    = state_q;
    clr_any_s  = clr_lat_q | clr_req_i;
    // An increment arriving in IDLE/INC_WR is loaded this cycle, so it counts as pending
    pend_any_s = pend_v_q | inc_req_i;
    case (state_q)
      S_IDLE, S_INC_WR: begin
        if (clr_any_s) begin
          state_d = S_CLEAR;
        end else if (pend_any_s) begin
          state_d = S_INC_RD;
        end else if (rd_req_i) begin
          state_d = S_HOST_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INC_RD:   state_d = S_INC_WR;
      S_HOST_RD:  state_d = S_HOST_RSP;
      S_HOST_RSP: state_d = S_IDLE;
      S_CLEAR: begin
        if (sweep_q == LAST_BIN) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Pending entry, clear latch, sweep counter and discarded-event accounting
  always_comb begin
    consume_s   = (state_q == S_INC_RD);
    enter_clr_s = (state_d == S_CLEAR) && (state_q != S_CLEAR);
    pend_v_d    = consume_s ? 1'b0 : pend_v_q;
    pend_addr_d = pend_addr_q;
    drops_s     = 2'd0;
    if (inc_req_i) begin
      if (state_q == S_CLEAR) begin
        drops_s = 2'd1;
      end else if (!pend_v_q || consume_s) begin
        pend_v_d    = 1'b1;
        pend_addr_d = inc_addr_i;
      end else begin
        drops_s = 2'd1;
      end
    end else begin
      drops_s = 2'd0;
    end
    if (enter_clr_s && pend_v_d) begin
      pend_v_d = 1'b0;
      drops_s  = drops_s + 2'd1;
    end else begin
      pend_v_d = pend_v_d;
    end
    drop_sum_s = {1'b0, drop_q} + (DROP_W+1)'(drops_s);
    if (drop_sum_s > DROP_MAX) begin
      drop_d = DROP_MAX[DROP_W-1:0];
    end else begin
      drop_d = drop_sum_s[DROP_W-1:0];
    end
    if (state_q == S_CLEAR || enter_clr_s) begin
      clr_lat_d = 1'b0;
    end else if (clr_req_i) begin
      clr_lat_d = 1'b1;
    end else begin
      clr_lat_d = clr_lat_q;
    end
    sweep_d    = (state_q == S_CLEAR) ? sweep_q + ADDR_W'(1) : '0;
    clr_done_d = (state_q == S_CLEAR) && (sweep_q == LAST_BIN);
    cur_addr_d = consume_s ? pend_addr_q : cur_addr_q;
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      cur_addr_q  <= '0;
      sweep_q     <= '0;
      clr_lat_q   <= 1'b0;
      clr_done_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      cur_addr_q  <= cur_addr_d;
      sweep_q     <= sweep_d;
      clr_lat_q   <= clr_lat_d;
      clr_done_q  <= clr_done_d;
      drop_q      <= drop_d;
    end
  end

  // RAM and host-side outputs decoded from the registered state
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    rd_data_o   = '0;
    rd_valid_o  = 1'b0;
    case (state_q)
      S_INC_RD:  mem_addr_o = pend_addr_q;
      S_INC_WR: begin
        mem_addr_o  = cur_addr_q;
        mem_we_o    = 1'b1;
        mem_wdata_o = sat_inc(mem_rdata_i);
      end
      S_HOST_RD: mem_addr_o = rd_addr_i;
      S_HOST_RSP: begin
        rd_data_o  = mem_rdata_i;
        rd_valid_o = 1'b1;
      end
      S_CLEAR: begin
        mem_addr_o = sweep_q;
        mem_we_o   = 1'b1;
      end
      default: mem_we_o = 1'b0;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign clr_done_o = clr_done_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_histogram_bin_ctrl.sv
// Self-checking bench for histogram_bin_ctrl: behavioural bin RAM, a bin-value model and
// scoreboards of expected RAM writes and host-read responses.
module tb_histogram_bin_ctrl;
  localparam int AW = 7;
  localparam int CW = 16;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          inc_req;
  logic [AW-1:0] inc_addr;
  logic          clr_req;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;
  logic          busy;
  logic          clr_done;
  logic [DW-1:0] drop_cnt;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [CW-1:0] bd_data;
  logic [CW-1:0] ram [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;
  int exp_bin [0:(1<<AW)-1];
  int exp_drop = 0;
  wr_t wr_q[$];
  logic [CW-1:0] rd_q[$];

  histogram_bin_ctrl #(.ADDR_W(AW), .CNT_W(CW), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inc_req_i(inc_req), .inc_addr_i(inc_addr), .clr_req_i(clr_req),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .clr_done_o(clr_done), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bin RAM with one-cycle read latency plus a bench backdoor for preloading
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write and read response is matched against the queues
  always @(negedge clk) begin
    wr_t w;
    logic [CW-1:0] r;
    if (rst_n && mem_we) begin
      if (wr_q.size() == 0) begin
        check_val("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        check_val("wr_addr", 32'(mem_addr), 32'(w.a));
        check_val("wr_data", 32'(mem_wdata), 32'(w.d));
      end
    end
    if (rst_n && rd_valid) begin
      if (rd_q.size() == 0) begin
        check_val("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        r = rd_q.pop_front();
        check_val("rd_data", 32'(rd_data), 32'(r));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_inc(input int a);
    wr_t e;
    int v;
    v = exp_bin[a] + 1;
    if (v > 65535) v = 65535;
    exp_bin[a] = v;
    e.a = AW'(a);
    e.d = CW'(v);
    wr_q.push_back(e);
  endtask

  task automatic exp_clear();
    wr_t e;
    for (int i = 0; i < (1 << AW); i++) begin
      e.a = AW'(i);
      e.d = '0;
      wr_q.push_back(e);
      exp_bin[i] = 0;
    end
  endtask

  task automatic backdoor(input int a, input int v);
    bd_we = 1'b1;
    bd_addr = AW'(a);
    bd_data = CW'(v);
    tick();
    bd_we = 1'b0;
    exp_bin[a] = v;
  endtask

  task automatic wait_clr_done(input int budget, output int cycles);
    cycles = 0;
    while (!clr_done && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; inc_req = 1'b0; inc_addr = '0; clr_req = 1'b0;
    rd_req = 1'b0; rd_addr = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < (1 << AW); i++) exp_bin[i] = 0;
    repeat (3) tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_we", 32'(mem_we), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_drop", 32'(drop_cnt), 32'd0);
    check_val("rst_rdv", 32'(rd_valid), 32'd0);
    check_val("rst_done", 32'(clr_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Initial clear from IDLE: 128 zero writes, then a one-cycle clr_done
    exp_clear();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check_val("clr0_busy", 32'(busy), 32'd1);
    wait_clr_done(300, cyc);
    check_val("clr0_done", 32'(clr_done), 32'd1);
    check_val("clr0_len", 32'(cyc), 32'd128);
    check_val("clr0_idle", 32'(busy), 32'd0);
    tick();
    check_val("clr0_pulse", 32'(clr_done), 32'd0);

    // Single increment from IDLE: bin 64 = 5 -> write 6 at N+2, busy for two cycles
    backdoor(64, 5);
    exp_inc(64);
    inc_req = 1'b1; inc_addr = 7'd64;
    tick();
    inc_req = 1'b0;
    check_val("inc_rd_busy", 32'(busy), 32'd1);
    check_val("inc_rd_we", 32'(mem_we), 32'd0);
    check_val("inc_rd_addr", 32'(mem_addr), 32'd64);
    tick();
    check_val("inc_wr_we", 32'(mem_we), 32'd1);
    check_val("inc_wr_data", 32'(mem_wdata), 32'd6);
    tick();
    check_val("inc_done_busy", 32'(busy), 32'd0);

    // Burst of three to bin 10: two counted, third dropped
    exp_inc(10);
    exp_inc(10);
    exp_drop++;
    inc_req = 1'b1; inc_addr = 7'd10;
    repeat (3) tick();
    inc_req = 1'b0;
    repeat (4) tick();
    check_val("burst_drop", 32'(drop_cnt), 32'(exp_drop));
    check_val("burst_idle", 32'(busy), 32'd0);

    // Saturation at full scale
    backdoor(3, 16'hFFFF);
    exp_inc(3);
    inc_req = 1'b1; inc_addr = 7'd3;
    tick();
    inc_req = 1'b0;
    repeat (4) tick();

    // Clear requested mid-RMW; increment during INC_WR is flushed, one during sweep dropped
    exp_inc(20);
    exp_clear();
    inc_req = 1'b1; inc_addr = 7'd20;
    tick();
    inc_req = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0; inc_req = 1'b1; inc_addr = 7'd30;
    exp_drop++;
    tick();
    inc_req = 1'b0;
    check_val("clr1_we", 32'(mem_we), 32'd1);
    check_val("clr1_addr", 32'(mem_addr), 32'd0);
    repeat (10) tick();
    inc_req = 1'b1; inc_addr = 7'd40; clr_req = 1'b1;
    exp_drop++;
    tick();
    inc_req = 1'b0; clr_req = 1'b0;
    wait_clr_done(300, cyc);
    check_val("clr1_done", 32'(clr_done), 32'd1);
    check_val("clr1_len", 32'(cyc), 32'd117);
    check_val("clr1_drop", 32'(drop_cnt), 32'(exp_drop));
    repeat (3) tick();
    check_val("clr1_no_resweep", 32'(busy), 32'd0);

    // Host read held off by an increment stream every two cycles
    backdoor(7, 42);
    rd_q.push_back(16'd42);
    rd_req = 1'b1; rd_addr = 7'd7;
    for (int i = 0; i < 5; i++) begin
      inc_req = 1'b1; inc_addr = 7'd1;
      exp_inc(1);
      tick();
      inc_req = 1'b0;
      check_val("rd_held_a", 32'(rd_valid), 32'd0);
      tick();
      check_val("rd_held_b", 32'(rd_valid), 32'd0);
    end
    cyc = 0;
    while (!rd_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    rd_req = 1'b0;
    check_val("rd_valid", 32'(rd_valid), 32'd1);
    check_val("rd_wait", 32'(cyc), 32'd2);
    repeat (3) tick();

    // Asynchronous reset while in INC_WR
    exp_inc(5);
    inc_req = 1'b1; inc_addr = 7'd5;
    tick();
    inc_req = 1'b0;
    tick();
    check_val("arst_pre_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_we", 32'(mem_we), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_drop", 32'(drop_cnt), 32'd0);
    exp_drop = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    check_val("post_rst_busy", 32'(busy), 32'd0);

    check_val("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check_val("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
